// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_drain
// Description : Read-side consumer of a show-ahead TX FIFO. Pops one word
//               whenever the FIFO is non-empty and serialises it onto the UART
//               TX line as start bit, DWIDTH data bits LSB-first, an optional
//               parity bit and one or two stop bits.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DWIDTH       data bits per frame (matches the FIFO word width)
//   CLKS_PER_BIT clk cycles per UART bit, >= 2
//   PARITY_EN    1 = append one parity bit after the data bits
//   PARITY_ODD   0 = even parity, 1 = odd parity (only when PARITY_EN = 1)
//   STOP_BITS    number of stop bits, 1 or 2
// Ports
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset
//   fifo_data  in   FIFO head word, valid while fifo_empty = 0
//   fifo_empty in   FIFO empty flag
//   fifo_ren   out  FIFO pop strobe, one clk per frame
//   tx         out  serial line, idle high, registered
//   busy       out  high from the cycle after the pop until the frame ends
//   tx_done    out  one-clk pulse on the final cycle of the last stop bit
// ============================================================================
module uart_tx_fifo_drain #(
    parameter int DWIDTH       = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DWIDTH-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_ren,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    // ------------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------------
    localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_bit_w  = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    // One cycle before terminal count; tx_done is registered, so it has to be
    // armed here to appear on the last cycle of the final stop bit.
    localparam logic [c_baud_w-1:0] c_baud_pre  = c_baud_w'(CLKS_PER_BIT - 2);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DWIDTH - 1);

    localparam logic c_parity_en  = (PARITY_EN  != 0);
    localparam logic c_parity_odd = (PARITY_ODD != 0);
    localparam logic c_two_stops  = (STOP_BITS  >  1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_baud_w-1:0] r_baud;
    logic [c_bit_w-1:0]  r_bit;
    logic                r_stop_idx;
    logic [DWIDTH-1:0]   r_shift;
    logic                r_parity;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;

    logic                w_pop;
    logic                w_baud_end;
    logic                w_last_stop;
    logic [DWIDTH-1:0]   w_shift_next;

    // The pop strobe is combinational so the byte is taken on the same edge
    // that the FSM leaves IDLE; it can never fire while the FIFO is empty.
    assign w_pop        = (r_state == ST_IDLE) & ~fifo_empty;
    assign w_baud_end   = (r_baud == c_baud_last);
    assign w_last_stop  = c_two_stops ? r_stop_idx : 1'b1;
    assign w_shift_next = r_shift >> 1;

    // ------------------------------------------------------------------------
    // Frame sequencer. tx is registered and always carries the value of the
    // bit that the state being entered owns, so each bit is on the line for
    // exactly CLKS_PER_BIT cycles starting the cycle after the transition.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_baud     <= '0;
                    r_bit      <= '0;
                    r_stop_idx <= 1'b0;
                    r_tx       <= 1'b1;
                    if (w_pop) begin
                        // The shift register owns the byte from here on; the
                        // FIFO head may change freely during the frame.
                        r_shift  <= fifo_data;
                        r_parity <= (^fifo_data) ^ c_parity_odd;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == c_bit_last) begin
                            r_bit <= '0;
                            if (c_parity_en) begin
                                r_tx    <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= w_shift_next;
                            r_tx    <= w_shift_next[0];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                ST_PARITY: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                ST_STOP: begin
                    r_tx <= 1'b1;
                    if (w_last_stop && (r_baud == c_baud_pre)) begin
                        r_done <= 1'b1;
                    end
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_last_stop) begin
                            r_stop_idx <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_baud  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign fifo_ren = w_pop;
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign tx_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo_drain
// Description : Self-checking bench for uart_tx_fifo_drain. Four instances
//               (plain, even parity, odd parity, two stop bits) each fed by a
//               small show-ahead FIFO model, with CLKS_PER_BIT = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_drain;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    // Show-ahead FIFO models, one per instance, 16 entries each.
    logic [7:0] mem [4][16];
    logic [4:0] wp  [4] = '{5'd0, 5'd0, 5'd0, 5'd0};
    logic [4:0] rp  [4] = '{5'd0, 5'd0, 5'd0, 5'd0};

    wire  [7:0] fdata [4];
    wire  [3:0] fempty;
    wire  [3:0] ren;
    wire  [3:0] tx;
    wire  [3:0] busy;
    wire  [3:0] done;

    for (genvar g = 0; g < 4; g++) begin : g_fifo
        assign fempty[g] = (wp[g] == rp[g]);
        assign fdata[g]  = mem[g][rp[g][3:0]];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ren[i]) rp[i] <= rp[i] + 5'd1;
        end
    end

    uart_tx_fifo_drain #(.DWIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_plain (
        .clk(clk), .rstn(rstn), .fifo_data(fdata[0]), .fifo_empty(fempty[0]),
        .fifo_ren(ren[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(done[0]));

    uart_tx_fifo_drain #(.DWIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk(clk), .rstn(rstn), .fifo_data(fdata[1]), .fifo_empty(fempty[1]),
        .fifo_ren(ren[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(done[1]));

    uart_tx_fifo_drain #(.DWIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rstn(rstn), .fifo_data(fdata[2]), .fifo_empty(fempty[2]),
        .fifo_ren(ren[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(done[2]));

    uart_tx_fifo_drain #(.DWIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rstn(rstn), .fifo_data(fdata[3]), .fifo_empty(fempty[3]),
        .fifo_ren(ren[3]), .tx(tx[3]), .busy(busy[3]), .tx_done(done[3]));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d);
        mem[i][wp[i][3:0]] = d;
        wp[i] = wp[i] + 5'd1;
    endtask

    // Pushes one byte and follows the whole frame. pat holds the expected
    // line levels in time order (bit 0 = start bit).
    task automatic run_frame(input int i, input logic [7:0] d, input int nbits,
                             input logic [11:0] pat, input string tag);
        logic [11:0] got;
        logic [11:0] unstable;
        int busy_bad;
        int done_cnt;
        int done_at;
        int ren_cnt;
        int b;
        got      = '0;
        unstable = '0;
        busy_bad = 0;
        done_cnt = 0;
        done_at  = -1;
        ren_cnt  = 0;
        @(negedge clk);
        push(i, d);
        #1;
        check({tag, "_ren"}, 32'(ren[i]), 32'd1);
        for (int k = 0; k < nbits * CPB; k++) begin
            @(negedge clk);
            b = k / CPB;
            if ((k % CPB) == 0) got[b] = tx[i];
            else if (tx[i] !== got[b]) unstable[b] = 1'b1;
            if (busy[i] !== 1'b1) busy_bad++;
            if (done[i] === 1'b1) begin
                done_cnt++;
                done_at = k + 1;
            end
            if (ren[i] !== 1'b0) ren_cnt++;
        end
        check({tag, "_bits"},     32'(got),      32'(pat));
        check({tag, "_bitwidth"}, 32'(unstable), 32'd0);
        check({tag, "_busy"},     32'(busy_bad), 32'd0);
        check({tag, "_donecnt"},  32'(done_cnt), 32'd1);
        check({tag, "_doneclk"},  32'(done_at),  32'(nbits * CPB));
        check({tag, "_renonce"},  32'(ren_cnt),  32'd0);
        @(negedge clk);
        check({tag, "_idle_tx"},   32'(tx[i]),   32'd1);
        check({tag, "_idle_busy"}, 32'(busy[i]), 32'd0);
    endtask

    typedef struct {
        int         dut;
        logic [7:0] data;
        int         nbits;
        logic [11:0] pat;
    } vec_t;

    vec_t vecs [10];

    logic       trace [160];
    int         rc [3];
    int         nren;
    int         bad_ren, bad_tx, bad_busy, bad_done;
    logic [7:0] dec;
    logic [7:0] exp_burst [3];
    int         s;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected line patterns, time order LSB first:
        // start, data LSB..MSB, [parity], stop(s).
        vecs[0] = '{0, 8'h55, 10, 12'b00_1010101010};
        vecs[1] = '{1, 8'h07, 11, 12'b0_11000001110};
        vecs[2] = '{2, 8'h07, 11, 12'b0_10000001110};
        vecs[3] = '{3, 8'h00, 11, 12'b0_11000000000};
        vecs[4] = '{0, 8'hA1, 10, 12'b00_1101000010};
        vecs[5] = '{0, 8'h3C, 10, 12'b00_1001111000};
        vecs[6] = '{0, 8'hFF, 10, 12'b00_1111111110};
        vecs[7] = '{1, 8'hA5, 11, 12'b0_10101001010};
        vecs[8] = '{2, 8'h00, 11, 12'b0_11000000000};
        vecs[9] = '{3, 8'h81, 11, 12'b0_11100000010};
        exp_burst[0] = 8'hA1;
        exp_burst[1] = 8'h3C;
        exp_burst[2] = 8'hFF;

        // Reset state
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx",   32'(tx),   32'hF);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_ren",  32'(ren),  32'h0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single frames from the vector table
        for (int n = 0; n < 10; n++) begin
            run_frame(vecs[n].dut, vecs[n].data, vecs[n].nbits, vecs[n].pat,
                      $sformatf("vec%0d", n));
            @(negedge clk);
        end

        // Burst of three bytes: back-to-back frames, one idle clk between
        @(negedge clk);
        push(0, 8'hA1);
        push(0, 8'h3C);
        push(0, 8'hFF);
        #1;
        nren = 0;
        rc   = '{0, 0, 0};
        for (int c = 0; c < 140; c++) begin
            if (c > 0) @(negedge clk);
            trace[c] = tx[0];
            if (ren[0] === 1'b1) begin
                if (nren < 3) rc[nren] = c;
                nren++;
            end
        end
        check("burst_ren_count", 32'(nren), 32'd3);
        check("burst_space01",   32'(rc[1] - rc[0]), 32'd41);
        check("burst_space12",   32'(rc[2] - rc[1]), 32'd41);
        for (int j = 0; j < 3; j++) begin
            s = rc[j] + 1;
            for (int bb = 0; bb < 8; bb++) dec[bb] = trace[s + CPB * (1 + bb) + 1];
            check($sformatf("burst_byte%0d", j), 32'(dec), 32'(exp_burst[j]));
        end
        for (int j = 0; j < 2; j++) begin
            s = rc[j] + 1;
            bad_tx = 0;
            for (int c = s + 36; c <= s + 40; c++) if (trace[c] !== 1'b1) bad_tx++;
            if (trace[s + 41] !== 1'b0) bad_tx++;
            check($sformatf("burst_gap%0d", j), 32'(bad_tx), 32'd0);
        end

        // Empty FIFO: nothing happens for 1000 clks
        bad_ren = 0; bad_tx = 0; bad_busy = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (ren  !== 4'h0) bad_ren++;
            if (tx   !== 4'hF) bad_tx++;
            if (busy !== 4'h0) bad_busy++;
        end
        check("empty_ren",  32'(bad_ren),  32'd0);
        check("empty_tx",   32'(bad_tx),   32'd0);
        check("empty_busy", 32'(bad_busy), 32'd0);

        // Reset in the middle of data bit 3 of 0x81
        @(negedge clk);
        push(0, 8'h81);
        for (int k = 0; k < 18; k++) @(negedge clk);
        check("rst_pre_busy", 32'(busy[0]), 32'd1);
        check("rst_pre_tx",   32'(tx[0]),   32'd0);
        rstn = 1'b0;
        #1;
        check("rst_tx",   32'(tx[0]),   32'd1);
        check("rst_busy", 32'(busy[0]), 32'd0);
        bad_done = 0; bad_ren = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done !== 4'h0) bad_done++;
            if (ren  !== 4'h0) bad_ren++;
        end
        rstn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done !== 4'h0) bad_done++;
            if (tx[0] !== 1'b1) bad_tx++;
        end
        check("rst_no_done", 32'(bad_done), 32'd0);
        check("rst_no_ren",  32'(bad_ren),  32'd0);
        run_frame(0, 8'h42, 10, 12'b00_1010000100, "rst_recover");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
